// File: rtl/spi_norflash_model_if.sv
// Parallel-word SPI bus between the NOR flash controller (master) and the flash model (slave).
interface spi_norflash_model_if #(
  parameter int LINEWIDE = 32
);
  logic                s_clk;
  logic                s_css;
  logic [LINEWIDE-1:0] s_mosi;
  logic [LINEWIDE-1:0] s_miso;

  modport master (
    output s_clk,
    output s_css,
    output s_mosi,
    input  s_miso
  );

  modport slave (
    input  s_clk,
    input  s_css,
    input  s_mosi,
    output s_miso
  );
endinterface

// File: rtl/spi_norflash_model.sv
// SPI NOR flash emulator: decodes one header word per frame and serves READ, PROGRAM,
// READ_STATUS, WREN and WRDI from a small word-wide memory, all in the p_clk domain.
module spi_norflash_model #(
  parameter int LINEWIDE     = 32,
  parameter int DEPTH        = 16,
  parameter bit REQUIRE_WREN = 1'b0
) (
  input  logic                p_clk,
  input  logic                p_rst,
  spi_norflash_model_if.slave spi,
  output logic                frame_done,
  output logic                err
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ADDRW = LINEWIDE - 8;

  localparam logic [7:0]       CMD_READ   = 8'h01;
  localparam logic [7:0]       CMD_PROG   = 8'h02;
  localparam logic [7:0]       CMD_WRDI   = 8'h04;
  localparam logic [7:0]       CMD_STATUS = 8'h05;
  localparam logic [7:0]       CMD_WREN   = 8'h06;
  localparam logic [ADDRW-1:0] DEPTH_A    = ADDRW'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD,
    ST_WR,
    ST_STAT,
    ST_IGNORE
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic                oor_q, oor_d;
  logic                prog_q, prog_d;
  logic                wel_q, wel_d;
  logic [LINEWIDE-1:0] miso_q, miso_d;
  logic                frame_done_q, frame_done_d;
  logic                err_q, err_d;
  logic                s_clk_q, s_css_q;

  logic [LINEWIDE-1:0] mem_q [DEPTH];
  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic [LINEWIDE-1:0] mem_wdata;

  logic                sclk_rise, css_fall, css_rise, word_take;
  logic [7:0]          hdr_cmd;
  logic [ADDRW-1:0]    hdr_addr;
  logic [AW-1:0]       hdr_idx, ptr_inc;
  logic                hdr_oor, wr_allowed;

  always_comb begin
    sclk_rise  = spi.s_clk & ~s_clk_q;
    css_fall   = ~spi.s_css & s_css_q;
    css_rise   = spi.s_css & ~s_css_q;
    word_take  = sclk_rise & ~spi.s_css;
    hdr_cmd    = spi.s_mosi[7:0];
    hdr_addr   = spi.s_mosi[LINEWIDE-1:8];
    hdr_oor    = (hdr_addr >= DEPTH_A);
    hdr_idx    = hdr_addr[AW-1:0];
    ptr_inc    = ptr_q + AW'(1);
    wr_allowed = ~oor_q & (wel_q | ~REQUIRE_WREN);
  end

  // Frame edges take priority over words: a word arriving with css_rise is dropped.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    oor_d        = oor_q;
    prog_d       = prog_q;
    wel_d        = wel_q;
    miso_d       = miso_q;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = ptr_q;
    mem_wdata    = spi.s_mosi;

    if (css_rise) begin
      state_d      = ST_IDLE;
      miso_d       = '0;
      frame_done_d = 1'b1;
      ptr_d        = '0;
      oor_d        = 1'b0;
      prog_d       = 1'b0;
      if (prog_q && REQUIRE_WREN) begin
        wel_d = 1'b0;
      end
    end else if (css_fall) begin
      state_d = ST_HDR;
      miso_d  = '0;
      ptr_d   = '0;
      oor_d   = 1'b0;
      prog_d  = 1'b0;
    end else if (word_take) begin
      case (state_q)
        ST_HDR: begin
          ptr_d = hdr_idx;
          oor_d = hdr_oor;
          case (hdr_cmd)
            CMD_READ: begin
              state_d = ST_RD;
              err_d   = hdr_oor;
              miso_d  = hdr_oor ? '0 : mem_q[hdr_idx];
            end
            CMD_PROG: begin
              state_d = ST_WR;
              err_d   = hdr_oor;
              prog_d  = 1'b1;
            end
            CMD_STATUS: begin
              state_d = ST_STAT;
              miso_d  = LINEWIDE'({wel_q, 1'b0});
            end
            CMD_WREN: begin
              state_d = ST_IGNORE;
              wel_d   = 1'b1;
            end
            CMD_WRDI: begin
              state_d = ST_IGNORE;
              wel_d   = 1'b0;
            end
            default: begin
              state_d = ST_IGNORE;
              err_d   = 1'b1;
            end
          endcase
        end
        ST_RD: begin
          ptr_d  = ptr_inc;
          miso_d = oor_q ? '0 : mem_q[ptr_inc];
        end
        ST_WR: begin
          if (wr_allowed) begin
            mem_we = 1'b1;
            ptr_d  = ptr_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // s_css_q resets high so a bus idling with chip select deasserted shows no edge.
  always_ff @(posedge p_clk or posedge p_rst) begin
    if (p_rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      oor_q        <= 1'b0;
      prog_q       <= 1'b0;
      wel_q        <= 1'b0;
      miso_q       <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      s_clk_q      <= 1'b0;
      s_css_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      oor_q        <= oor_d;
      prog_q       <= prog_d;
      wel_q        <= wel_d;
      miso_q       <= miso_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      s_clk_q      <= spi.s_clk;
      s_css_q      <= spi.s_css;
    end
  end

  always_ff @(posedge p_clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign spi.s_miso = miso_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule

// File: doc/spi_norflash_model.md
Name: spi_norflash_model

Overview:
Synthesizable SPI NOR flash emulator that sits directly downstream of the APB-to-SPI NOR flash controller and consumes its s_clk / s_css / s_mosi bus. It answers on s_miso. It replaces the ad-hoc flash behaviour in the controller bench and can also be placed on FPGA prototypes. The SPI bus uses the codebase's 32-bit parallel word lines: one LINEWIDE-bit word is transferred per s_clk rising edge. The block is clocked by p_clk. s_clk and s_css are generated by the controller from p_clk, so no synchronizer is required; edges are detected with one register stage.

Parameters:
LINEWIDE, 32, width of s_mosi/s_miso words
DEPTH, 16, number of LINEWIDE-bit storage words (power of two, >=2)
REQUIRE_WREN, 0, 1 = program command accepted only after WREN

Ports:
p_clk  input  1  system clock; all state updates on rising edge
p_rst  input  1  asynchronous, active-high reset
s_clk  input  1  SPI clock from controller; sampled in p_clk domain
s_css  input  1  SPI chip select, active-low; frame = low period
s_mosi  input  LINEWIDE  controller-to-flash word
s_miso  output  LINEWIDE  flash-to-controller word
frame_done  output  1  one-p_clk pulse on s_css rising edge that ends a frame
err  output  1  one-p_clk pulse on an unknown command or an out-of-range address

Behaviour:
- Reset (async, p_rst=1): s_miso=0, frame_done=0, err=0, state=IDLE, word counter=0, wel=0. Memory contents are not reset; the bench preloads or writes them.
- Edge detect: registered s_clk_q/s_css_q. sclk_rise = s_clk & ~s_clk_q. css_fall / css_rise are derived the same way from s_css.
- Header word (first sclk_rise in a frame): cmd = s_mosi[7:0], addr = s_mosi[31:8]. Word index = addr[log2(DEPTH)-1:0].
- Commands:
  - 0x01 READ
  - 0x02 PROGRAM
  - 0x05 READ_STATUS
  - 0x06 WREN
  - 0x04 WRDI
  - Any other value: err pulse, state=IGNORE until css_rise.
- States:
  - IDLE: on css_fall -> HDR.
  - HDR: on sclk_rise, decode the header:
    - READ -> RD
    - PROGRAM -> WR
    - READ_STATUS -> ST
    - WREN/WRDI -> set/clear wel, then IGNORE
  - RD: s_miso = mem[ptr], registered the p_clk cycle after the header edge (latency 1 p_clk; stable before the next s_clk rise). Each further sclk_rise: ptr = ptr+1, s_miso updates 1 p_clk later.
  - WR: each sclk_rise: if (wel | ~REQUIRE_WREN), mem[ptr] = s_mosi and ptr = ptr+1.
  - ST: s_miso = {zeros, wel, 1'b0}, held for the whole frame.
  - IGNORE: no action.
- Any state: css_rise -> IDLE, s_miso=0, frame_done pulse, word counter=0. If the last command was PROGRAM and REQUIRE_WREN=1, wel clears.
- Out-of-range address (addr >= DEPTH): err pulse at the header. READ returns 0 for all words; PROGRAM writes nothing.
- Pointer wrap: ptr increments modulo DEPTH (DEPTH-1 -> 0). No err on wrap.
- Simultaneous css_rise and sclk_rise in the same p_clk: css_rise wins; the word is dropped.
- css_fall while not IDLE (glitch / no rise seen): restart in HDR.
- sclk_rise while s_css=1: ignored.
- Reset mid-frame: immediate return to the reset values above. Memory words already written stay written.

Test Plan:
- Reset then program: frame header {24'd0, 8'h02}, data 32'hFF00FF00 -> mem[0]=32'hFF00FF00, frame_done pulses once, err stays 0.
- Read back: header {24'd0, 8'h01} -> s_miso=32'hFF00FF00 one p_clk after the header s_clk rise, and s_miso=0 after s_css rises.
- Burst wrap (DEPTH=16): program at addr 15 with 3 words A, B, C -> mem[15]=A, mem[0]=B, mem[1]=C. A read burst from 15 returns A, B, C.
- REQUIRE_WREN=1:
  - PROGRAM without WREN -> mem unchanged.
  - WREN frame, then PROGRAM 32'h12345678 at addr 2 -> mem[2]=32'h12345678.
  - READ_STATUS before the PROGRAM frame ends shows s_miso=32'h2; READ_STATUS after it shows 32'h0.
- Bad input: cmd 8'hAA -> err pulse, no memory change. READ at addr 24'd16 -> err pulse, s_miso=0.
- Async reset asserted mid-PROGRAM burst after 1 of 3 words -> outputs at reset values immediately. Only the first word is written. The next frame decodes normally.
